// File: rtl/des_loader.sv
// DES loader: assembles a 16-byte frame (8 key bytes, then 8 plaintext bytes)
// from the asynchronous Xmega byte interface, then hands the block to the DES core.
// The core is started once it is idle, and the loader waits for its done pulse.
// Optional feature: define DES_LOADER_PARITY_EN to check every key byte for odd
// parity before starting DES. A bad key sets err[2] and drops the frame.
// Without the macro, parity is ignored and err[2] stays 0.

module des_loader #(
    parameter int TIMEOUT = 50000000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [7:0]  cm_data,
    input  logic        cm_strobe,
    input  logic        des_busy,
    input  logic        des_done,
    output logic [63:0] des_key,
    output logic [63:0] des_block,
    output logic        des_start,
    output logic [3:0]  byte_cnt,
    output logic [2:0]  state,
    output logic [2:0]  err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEY   = 3'd1,
        TEXT  = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4
    } state_t;

    // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    strobeSync_q;
    logic [7:0]    dataSync0_q;
    logic [7:0]    dataSync1_q;
    logic          strobeEdge;

    state_t        state_q;
    logic [63:0]   key_q;
    logic [63:0]   block_q;
    logic [3:0]    byteCnt_q;
    logic [2:0]    err_q;
    logic [TW-1:0] tmoCnt_q;

    // Byte slot within the key or block, MSB first.
    // byte_cnt 0..7 selects a key byte, and 8..15 selects a block byte.
    logic [5:0]    slotLsb;
    assign slotLsb = {~byteCnt_q[2:0], 3'b000};

`ifdef DES_LOADER_PARITY_EN
    function automatic logic keyParityOk(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!(^k[8*i +: 8])) ok = 1'b0;
        end
        return ok;
    endfunction
`endif

    // Two-flop synchronizers for strobe and data.
    // A third strobe flop holds the previous synchronized value for edge detection.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            strobeSync_q <= 3'b000;
            dataSync0_q  <= 8'h00;
            dataSync1_q  <= 8'h00;
        end else begin
            strobeSync_q <= {strobeSync_q[1:0], cm_strobe};
            dataSync0_q  <= cm_data;
            dataSync1_q  <= dataSync0_q;
        end
    end

    assign strobeEdge = strobeSync_q[1] & ~strobeSync_q[2];

    // Frame FSM.
    // Captures bytes, enforces the inter-byte timeout, and records sticky errors.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            key_q     <= 64'h0;
            block_q   <= 64'h0;
            byteCnt_q <= 4'd0;
            err_q     <= 3'b000;
            tmoCnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tmoCnt_q <= '0;
                    if (strobeEdge) begin
                        key_q[63:56] <= dataSync1_q;
                        byteCnt_q    <= 4'd1;
                        state_q      <= KEY;
                    end
                end
                KEY: begin
                    if (strobeEdge) begin
                        key_q[slotLsb +: 8] <= dataSync1_q;
                        tmoCnt_q            <= '0;
                        byteCnt_q           <= byteCnt_q + 4'd1;
                        if (byteCnt_q == 4'd7) state_q <= TEXT;
                    end else if (tmoCnt_q == TMO_LAST) begin
                        err_q[0]  <= 1'b1;
                        byteCnt_q <= 4'd0;
                        tmoCnt_q  <= '0;
                        state_q   <= IDLE;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + TW'(1);
                    end
                end
                TEXT: begin
                    if (strobeEdge) begin
                        block_q[slotLsb +: 8] <= dataSync1_q;
                        tmoCnt_q              <= '0;
                        if (byteCnt_q == 4'd15) begin
                            byteCnt_q <= 4'd0;
`ifdef DES_LOADER_PARITY_EN
                            if (keyParityOk(key_q)) begin
                                state_q <= START;
                            end else begin
                                err_q[2] <= 1'b1;
                                state_q  <= IDLE;
                            end
`else
                            state_q <= START;
`endif
                        end else begin
                            byteCnt_q <= byteCnt_q + 4'd1;
                        end
                    end else if (tmoCnt_q == TMO_LAST) begin
                        err_q[0]  <= 1'b1;
                        byteCnt_q <= 4'd0;
                        tmoCnt_q  <= '0;
                        state_q   <= IDLE;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + TW'(1);
                    end
                end
                START: begin
                    tmoCnt_q <= '0;
                    if (strobeEdge) err_q[1] <= 1'b1;
                    if (!des_busy) state_q <= WAIT;
                end
                WAIT: begin
                    tmoCnt_q <= '0;
                    if (strobeEdge) err_q[1] <= 1'b1;
                    if (des_done) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The start pulse is decoded from the registered state and the live busy input.
    // This fires it in the first START cycle where the core is free.
    // START is left on that same edge, so the pulse lasts exactly one cycle.
    assign des_start = (state_q == START) && !des_busy;

    assign des_key   = key_q;
    assign des_block = block_q;
    assign byte_cnt  = byteCnt_q;
    assign state     = state_q;
    assign err       = err_q;

endmodule
